vga_driver: RTL and testbench

VGA_DRIVER -- requirements
Module: vga_driver

---
 rtl/vga_driver.sv | 110 +++++++++++
 tb/tb_vga_driver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_driver.sv
// VGA timing generator with a registered colour/sync output stage; outputs lag the coordinates by 1 cycle.
// No backpressure: the pixel source must answer (o_x, o_y) combinationally in the same cycle.
module vga_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  input  logic [23:0] i_rgb,
  output logic [7:0]  o_vga_r,
  output logic [7:0]  o_vga_g,
  output logic [7:0]  o_vga_b,
  output logic        o_vga_hs,
  output logic        o_vga_vs,
  output logic        o_vga_blank_n,
  output logic        o_vga_sync_n,
  output logic        o_frame_end,
  output logic [7:0]  o_frame_cnt
);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       active;
  logic       hs_raw;
  logic       vs_raw;
  rgb_t       pix_in;
  rgb_t       pix_q;

  assign h_last = (h_cnt == H_MAX);
  assign v_last = (v_cnt == V_MAX);

  // v_cnt only moves at line wrap, so vsync edges always land on h_cnt = 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_raw      = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
    vs_raw      = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
    o_x         = active ? h_cnt : '0;
    o_y         = active ? v_cnt[8:0] : '0;
    o_frame_end = h_last && v_last;
    pix_in      = i_rgb;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix_q         <= '0;
      o_vga_hs      <= 1'b1;
      o_vga_vs      <= 1'b1;
      o_vga_blank_n <= 1'b0;
    end else begin
      pix_q         <= active ? pix_in : '0;
      o_vga_hs      <= hs_raw;
      o_vga_vs      <= vs_raw;
      o_vga_blank_n <= active;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
    end else if (o_frame_end) begin
      o_frame_cnt <= o_frame_cnt + 8'd1;
    end
  end

  assign o_vga_r      = pix_q.r;
  assign o_vga_g      = pix_q.g;
  assign o_vga_b      = pix_q.b;
  assign o_vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_driver.sv
// Self-checking bench for vga_driver using a reduced raster so many frames fit in a short run.
module tb_vga_driver;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;   // 15
  localparam int VT = VA + VFP + VS + VBP;   // 10
  localparam int FT = HT * VT;               // 150

  logic        clk;
  logic        rst;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic [23:0] rgb;
  logic [7:0]  vr, vg, vb;
  logic        hs, vs, blank_n, sync_n, frame_end;
  logic [7:0]  frame_cnt;

  vga_driver #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .o_x(o_x), .o_y(o_y), .i_rgb(rgb),
    .o_vga_r(vr), .o_vga_g(vg), .o_vga_b(vb),
    .o_vga_hs(hs), .o_vga_vs(vs), .o_vga_blank_n(blank_n),
    .o_vga_sync_n(sync_n), .o_frame_end(frame_end), .o_frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // 0: constant orange, 1: colour derived from coordinates, 2: random per cycle
  int          mode = 0;
  logic [23:0] rnd = 24'h0;

  always_comb begin
    case (mode)
      0:       rgb = 24'hFF8000;
      1:       rgb = {o_x[7:0], o_y[7:0], 8'h55};
      default: rgb = rnd;
    endcase
  end

  always @(posedge clk) rnd <= 24'($urandom);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: n = edges since the last reset edge; raster position is n mod period.
  int          n = 0;
  bit          started = 0;
  bit          have_prev = 0;
  logic [23:0] prev_rgb = '0;
  int          prev_mode = 0;

  always @(posedge clk) begin
    if (rst) begin
      n         <= 0;
      have_prev <= 0;
      started   <= 1;
    end else begin
      n         <= n + 1;
      have_prev <= 1;
    end
    prev_rgb  <= rgb;
    prev_mode <= mode;
  end

  always @(negedge clk) begin
    if (started) begin
      int h, v, ph, pv;
      bit vis, pvis;
      logic [23:0] exp_rgb;
      h   = n % HT;
      v   = (n / HT) % VT;
      vis = (h < HA) && (v < VA);
      check("pos", {o_x, o_y}, vis ? {10'(h), 9'(v)} : 19'd0);
      check("frame_end", frame_end, (h == HT - 1) && (v == VT - 1));
      check("frame_cnt", frame_cnt, (n / FT) % 256);
      if (have_prev) begin
        ph   = (n - 1) % HT;
        pv   = ((n - 1) / HT) % VT;
        pvis = (ph < HA) && (pv < VA);
        if (!pvis)               exp_rgb = 24'h0;
        else if (prev_mode == 1) exp_rgb = {8'(ph), 8'(pv), 8'h55};
        else                     exp_rgb = prev_rgb;
        check("sync", {hs, vs, blank_n, sync_n},
              {!(ph >= HA + HFP && ph < HA + HFP + HS),
               !(pv >= VA + VFP && pv < VA + VFP + VS), pvis, 1'b0});
        check("pixel", {vr, vg, vb}, exp_rgb);
      end else begin
        check("sync_rst", {hs, vs, blank_n, sync_n}, 4'b1100);
        check("pixel_rst", {vr, vg, vb}, 24'h0);
      end
    end
  end

  task automatic wait_fe(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_end && cyc < 2 * FT);
    check("frame_end_seen", frame_end, 1'b1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int cyc, blank_cnt, hs_low, vs_low, k;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // First cycle after release: origin, outputs still in reset state.
    @(negedge clk);
    check("rst_xy", {o_x, o_y}, 19'd0);
    check("rst_sync", {hs, vs, blank_n}, 3'b110);
    check("rst_rgb", {vr, vg, vb}, 24'h0);
    check("rst_fc", frame_cnt, 8'd0);

    // One line of constant colour: 8 visible pixels, 3 cycles of hsync.
    blank_cnt = 0;
    hs_low = 0;
    for (int i = 0; i < HT; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("first_pix", {vr, vg, vb}, 24'hFF8000);
        check("first_blank", blank_n, 1'b1);
        check("x_step", o_x, 10'd1);
      end
      if (blank_n) blank_cnt++;
      if (!hs) hs_low++;
    end
    check("line_visible", blank_cnt, HA);
    check("line_hs_low", hs_low, HS);

    // Frame period, vsync width and frame counter step.
    wait_fe(cyc);
    check("fc_before", frame_cnt, 8'd0);
    cyc = 0;
    vs_low = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!vs) vs_low++;
    end while (!frame_end && cyc < 2 * FT);
    check("frame_period", cyc, FT);
    check("vs_low", vs_low, VS * HT);
    check("fc_after", frame_cnt, 8'd1);

    mode = 1;
    repeat (2 * FT) @(negedge clk);
    mode = 2;
    repeat (2 * FT) @(negedge clk);

    // Mid-frame reset at a known position.
    cyc = 0;
    while (!(o_x == 10'd5 && o_y == 9'd3) && cyc < 2 * FT) begin
      @(negedge clk);
      cyc++;
    end
    check("found_pos", {o_x, o_y}, {10'd5, 9'd3});
    pulse_reset();
    @(negedge clk);
    check("mid_xy", {o_x, o_y}, 19'd0);
    check("mid_sync", {hs, vs, blank_n}, 3'b110);
    check("mid_rgb", {vr, vg, vb}, 24'h0);
    check("mid_fc", frame_cnt, 8'd0);

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 300)) @(negedge clk);
      pulse_reset();
    end

    // Counter wrap over 256 frames.
    pulse_reset();
    for (k = 1; k <= 256; k++) wait_fe(cyc);
    check("fc_255", frame_cnt, 8'd255);
    @(negedge clk);
    check("fc_wrap", frame_cnt, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
